// File: rtl/dcache_assoc.sv
// dcache_assoc: 2-way set-associative write-back, write-allocate data cache.
// CPU side: READ_EN/WRITE_EN/BYTE_EN/address/WRITE_DATA -> READ_DATA/busywait.
// Memory side: mem_read/mem_write/mem_address/mem_WRITE_DATA <-> mem_READ_DATA/mem_busywait.
module dcache_assoc #(
  parameter int SET_BITS    = 3,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_W       = 30 - SET_BITS - OFFSET_BITS,
  parameter int LINE_W      = 32 << OFFSET_BITS
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic                     READ_EN,
  input  logic                     WRITE_EN,
  input  logic [3:0]               BYTE_EN,
  input  logic [31:0]              address,
  input  logic [31:0]              WRITE_DATA,
  output logic [31:0]              READ_DATA,
  output logic                     busywait,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [29-OFFSET_BITS:0]  mem_address,
  output logic [LINE_W-1:0]        mem_WRITE_DATA,
  input  logic [LINE_W-1:0]        mem_READ_DATA,
  input  logic                     mem_busywait
);
  localparam int SETS = 1 << SET_BITS;

  typedef enum logic [1:0] {
    S_IDLE, S_WB, S_FETCH, S_FILL
  } state_t;

  state_t r_state, w_next;

  logic [SETS-1:0]   r_valid [2];
  logic [SETS-1:0]   r_dirty [2];
  logic [SETS-1:0]   r_lru;
  logic [TAG_W-1:0]  r_tag  [2][SETS];
  logic [LINE_W-1:0] r_data [2][SETS];
  logic [LINE_W-1:0] r_fill;

  logic [TAG_W-1:0]       w_tag;
  logic [SET_BITS-1:0]    w_idx;
  logic [OFFSET_BITS-1:0] w_off;
  logic w_hit0, w_hit1, w_hit, w_hway;
  logic w_req, w_wr, w_vict, w_vdirty;
  logic w_req_hit, w_wr_hit;
  logic [LINE_W-1:0] w_hline, w_base, w_merged;
  logic [31:0] w_word;
  logic w_unused_ok;

  assign w_tag = address[31 -: TAG_W];
  assign w_idx = address[OFFSET_BITS+2 +: SET_BITS];
  assign w_off = address[2 +: OFFSET_BITS];
  assign w_unused_ok = &{1'b0, address[1:0]};

  assign w_hit0 = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1 = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit  = w_hit0 | w_hit1;
  assign w_hway = w_hit1;

  // A simultaneous read and write is handled as a write.
  assign w_req = READ_EN | WRITE_EN;
  assign w_wr  = WRITE_EN;

  assign w_req_hit = (r_state == S_IDLE) && w_req && w_hit;
  assign w_wr_hit  = (r_state == S_IDLE) && w_wr && w_hit;

  // Fill invalid ways first, otherwise evict the least recently used.
  assign w_vict = !r_valid[0][w_idx] ? 1'b0 :
                  !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
  assign w_vdirty = r_valid[w_vict][w_idx] && r_dirty[w_vict][w_idx];

  assign w_hline = r_data[w_hway][w_idx];

  assign READ_DATA = (RESET_N && READ_EN && w_hit) ?
                     w_hline[{w_off, 5'd0} +: 32] : 32'd0;

  // Byte merge into either the hit line or the pending fill line.
  always_comb begin
    w_base   = (r_state == S_FILL) ? r_fill : w_hline;
    w_merged = w_base;
    w_word   = w_base[{w_off, 5'd0} +: 32];
    for (int b = 0; b < 4; b++) begin
      if (BYTE_EN[b]) w_word[8*b +: 8] = WRITE_DATA[8*b +: 8];
    end
    w_merged[{w_off, 5'd0} +: 32] = w_word;
  end

  always_comb begin
    w_next         = r_state;
    busywait       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_WRITE_DATA = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req && !w_hit) begin
          busywait = 1'b1;
          w_next   = w_vdirty ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        busywait       = 1'b1;
        mem_write      = 1'b1;
        mem_address    = {r_tag[w_vict][w_idx], w_idx};
        mem_WRITE_DATA = r_data[w_vict][w_idx];
        if (!mem_busywait) w_next = S_FETCH;
      end
      S_FETCH: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = address[31:OFFSET_BITS+2];
        if (!mem_busywait) w_next = S_FILL;
      end
      S_FILL: begin
        busywait = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Pipeline must see a quiet cache while reset is held.
    if (!RESET_N) begin
      busywait = 1'b0;
    end
  end

  always_ff @(negedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_dirty[0] <= '0;
      r_dirty[1] <= '0;
      r_lru      <= '0;
    end else begin
      r_state <= w_next;
      if (w_req_hit) begin
        r_lru[w_idx] <= ~w_hway;
        if (w_wr) r_dirty[w_hway][w_idx] <= 1'b1;
      end
      if (r_state == S_FILL) begin
        r_valid[w_vict][w_idx] <= 1'b1;
        r_dirty[w_vict][w_idx] <= w_wr;
        r_lru[w_idx]           <= ~w_vict;
      end
    end
  end

  // Line data and tags carry no reset; valid bits guard them.
  always_ff @(negedge CLOCK) begin
    if (r_state == S_FETCH && !mem_busywait) begin
      r_fill <= mem_READ_DATA;
    end
    if (w_wr_hit) begin
      r_data[w_hway][w_idx] <= w_merged;
    end
    if (r_state == S_FILL) begin
      r_data[w_vict][w_idx] <= w_wr ? w_merged : r_fill;
      r_tag[w_vict][w_idx]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: transaction-level cache model predicting per-cycle outputs.
// Directed accesses plus literal pins for hit/miss/evict/reset behaviour.
module tb_dcache_assoc;
  logic         CLOCK;
  logic         RESET_N;
  logic         READ_EN;
  logic         WRITE_EN;
  logic [3:0]   BYTE_EN;
  logic [31:0]  address;
  logic [31:0]  WRITE_DATA;
  logic [31:0]  READ_DATA;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_WRITE_DATA;
  logic [127:0] mem_READ_DATA;
  logic         mem_busywait;

  dcache_assoc dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .READ_EN(READ_EN), .WRITE_EN(WRITE_EN),
    .BYTE_EN(BYTE_EN), .address(address),
    .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA),
    .busywait(busywait), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address),
    .mem_WRITE_DATA(mem_WRITE_DATA),
    .mem_READ_DATA(mem_READ_DATA),
    .mem_busywait(mem_busywait)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  int L = 2;

  task automatic chk(string name, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit [127:0] mem_init(bit [27:0] a);
    bit [31:0] w;
    w = {4'hA, a};
    return {w ^ 32'd3, w ^ 32'd2, w ^ 32'd1, w};
  endfunction

  // Emulated memory device: L cycles per transaction.
  bit [127:0] phys [bit [27:0]];
  int kind = 0, pkind = 0, cnt = 0;

  always @(posedge CLOCK) begin
    kind = mem_write ? 2 : (mem_read ? 1 : 0);
    if (kind == 0) cnt = 0;
    else if (kind == pkind) cnt++;
    else cnt = 1;
    pkind = kind;
    mem_busywait = (kind != 0) && (cnt < L);
    if (mem_read)
      mem_READ_DATA = phys.exists(mem_address) ?
                      phys[mem_address] : mem_init(mem_address);
    if (kind == 2 && cnt >= L)
      phys[mem_address] = mem_WRITE_DATA;
  end

  // Reference cache, tracked by line address per way.
  bit         m_valid [2][8];
  bit         m_dirty [2][8];
  bit [27:0]  m_la    [2][8];
  bit [127:0] m_line  [2][8];
  bit         m_lru   [8];
  bit [127:0] ref_mem [bit [27:0]];

  function automatic bit [127:0] ref_get(bit [27:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  typedef struct {
    bit         busy;
    bit         mr;
    bit         mw;
    bit [27:0]  ma;
    bit [127:0] md;
    bit [31:0]  rd;
  } exp_t;

  exp_t expq[$];

  task automatic push(bit busy, bit mr, bit mw, bit [27:0] ma,
                      bit [127:0] md, bit [31:0] rd);
    exp_t e;
    e.busy = busy; e.mr = mr; e.mw = mw;
    e.ma = ma; e.md = md; e.rd = rd;
    expq.push_back(e);
  endtask

  logic [31:0]  last_rd;
  logic [27:0]  wb_addr_seen, fetch_addr_seen;
  logic [127:0] wb_data_seen;

  always begin
    exp_t e;
    @(posedge CLOCK);
    #3;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("busywait", busywait, e.busy);
      chk("mem_read", mem_read, e.mr);
      chk("mem_write", mem_write, e.mw);
      chk("mem_address", mem_address, e.ma);
      chk("mem_WRITE_DATA", mem_WRITE_DATA, e.md);
      chk("READ_DATA", READ_DATA, e.rd);
      if (mem_write) begin
        wb_addr_seen = mem_address;
        wb_data_seen = mem_WRITE_DATA;
      end
      if (mem_read) fetch_addr_seen = mem_address;
      if (!e.busy) last_rd = READ_DATA;
    end
  end

  // Entered and left at posedge+1.
  task automatic access(bit rd, bit wr, bit [31:0] addr,
                        bit [3:0] be, bit [31:0] wd);
    bit [27:0] la;
    int s, wi, h, v, n;
    bit [31:0] word;
    la = addr[31:4];
    s  = int'(la[2:0]);
    wi = int'(addr[3:2]);
    h  = -1;
    n  = 0;
    for (int i = 0; i < 2; i++)
      if (m_valid[i][s] && m_la[i][s] == la) h = i;
    if (h < 0) begin
      v = !m_valid[0][s] ? 0 : (!m_valid[1][s] ? 1 : int'(m_lru[s]));
      push(1, 0, 0, 0, 0, 0); n++;
      if (m_valid[v][s] && m_dirty[v][s]) begin
        repeat (L) push(1, 0, 1, m_la[v][s], m_line[v][s], 0);
        n += L;
        ref_mem[m_la[v][s]] = m_line[v][s];
      end
      repeat (L) push(1, 1, 0, la, 0, 0);
      n += L;
      push(1, 0, 0, 0, 0, 0); n++;
      m_line[v][s]  = ref_get(la);
      m_la[v][s]    = la;
      m_valid[v][s] = 1'b1;
      m_dirty[v][s] = 1'b0;
      h = v;
    end
    word = m_line[h][s][wi*32 +: 32];
    push(0, 0, 0, 0, 0, rd ? word : 32'd0); n++;
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
      m_line[h][s][wi*32 +: 32] = word;
      m_dirty[h][s] = 1'b1;
    end
    m_lru[s] = (h == 0);
    READ_EN    = rd;
    WRITE_EN   = wr;
    address    = addr;
    BYTE_EN    = be;
    WRITE_DATA = wd;
    repeat (n) @(posedge CLOCK);
    #1;
    READ_EN  = 1'b0;
    WRITE_EN = 1'b0;
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < 8; s++) m_lru[s] = 1'b0;
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, " busywait"}, busywait, 1'b0);
    chk({tag, " mem_read"}, mem_read, 1'b0);
    chk({tag, " mem_write"}, mem_write, 1'b0);
    chk({tag, " mem_address"}, mem_address, 28'd0);
    chk({tag, " mem_WRITE_DATA"}, mem_WRITE_DATA, 128'd0);
    chk({tag, " READ_DATA"}, READ_DATA, 32'd0);
  endtask

  initial begin
    bit [127:0] line4;
    RESET_N = 1'b0; READ_EN = 1'b1; WRITE_EN = 1'b0;
    BYTE_EN = 4'h0; address = 32'h40; WRITE_DATA = 32'd0;
    mem_busywait = 1'b0; mem_READ_DATA = '0;
    model_reset();
    line4 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    phys[28'h4] = line4;
    ref_mem[28'h4] = line4;
    #12;
    chk_quiet("reset");
    READ_EN = 1'b0;
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    @(posedge CLOCK); #1;

    // Clean miss then fill from memory.
    L = 2;
    fetch_addr_seen = '1;
    access(1, 0, 32'h40, 4'h0, 0);
    chk("fetch addr 0x40", fetch_addr_seen, 28'h4);
    chk("read 0x40", last_rd, 32'h1111_1111);

    // Second way of set 4, then hits on both.
    access(1, 0, 32'h440, 4'h0, 0);
    chk("read 0x440", last_rd, 32'hA000_0044);
    access(1, 0, 32'h40, 4'h0, 0);
    access(1, 0, 32'h440, 4'h0, 0);

    // Partial store hit.
    access(0, 1, 32'h40, 4'b0011, 32'hDEAD_BEEF);
    access(1, 0, 32'h40, 4'h0, 0);
    chk("merged 0x40", last_rd, 32'h1111_BEEF);
    chk("model dirty way0", m_dirty[0][4], 1'b1);

    // Dirty eviction of way 0.
    L = 3;
    access(1, 0, 32'h440, 4'h0, 0);
    chk("model lru set4", m_lru[4], 1'b0);
    access(1, 0, 32'h840, 4'h0, 0);
    chk("wb addr", wb_addr_seen, 28'h4);
    chk("wb word0", wb_data_seen[31:0], 32'h1111_BEEF);
    chk("fetch addr 0x840", fetch_addr_seen, 28'h84);
    chk("read 0x840", last_rd, 32'hA000_0084);

    // Write miss allocates and merges.
    L = 1;
    access(0, 1, 32'h2C, 4'hF, 32'hCAFE_F00D);
    access(1, 0, 32'h2C, 4'h0, 0);
    chk("read 0x2C", last_rd, 32'hCAFE_F00D);
    access(1, 0, 32'h20, 4'h0, 0);
    chk("read 0x20", last_rd, 32'hA000_0002);
    access(1, 0, 32'h22C, 4'h0, 0);
    access(1, 0, 32'h42C, 4'h0, 0);
    chk("wb addr set2", wb_addr_seen, 28'h2);
    chk("wb word3", wb_data_seen[127:96], 32'hCAFE_F00D);
    access(1, 0, 32'h2C, 4'h0, 0);
    chk("refetch 0x2C", last_rd, 32'hCAFE_F00D);

    // Read and write together act as a write.
    L = 2;
    access(1, 1, 32'h440, 4'b1100, 32'h1234_5678);
    access(1, 0, 32'h440, 4'h0, 0);
    chk("rw merge 0x440", last_rd, 32'h1234_0044);
    access(0, 1, 32'h840, 4'b0001, 32'h0000_00EE);

    // Reset in the middle of a writeback.
    L = 4;
    READ_EN = 1'b1; address = 32'hC40;
    @(posedge CLOCK); #1;
    @(posedge CLOCK); #1;
    chk("wb in flight", mem_write, 1'b1);
    chk("wb stall", busywait, 1'b1);
    RESET_N = 1'b0;
    #1;
    chk_quiet("mid-wb reset");
    model_reset();
    READ_EN = 1'b0;
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    @(posedge CLOCK); #1;
    L = 2;
    fetch_addr_seen = '1;
    access(1, 0, 32'h40, 4'h0, 0);
    chk("post-reset miss", fetch_addr_seen, 28'h4);
    chk("post-reset read", last_rd, 32'h1111_BEEF);

    repeat (3) @(posedge CLOCK);
    chk("queue drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
